vga_pxl_unpack: RTL and testbench

Single-clock stage directly downstream of the pixel FIFO read port. It pops 32-bit memory words (registered read data, one-cycle latency) and unpacks them into 24-bit RGB pixels for the colour/timing stage. Supported formats: 32bpp, 24bpp packed, 16bpp RGB565 and 8bpp greyscale. A valid/ready handshake on the pixel side provides back-pressure toward the FIFO.

---
 rtl/vga_pxl_unpack_if.sv | 29 ++
 rtl/vga_pxl_unpack.sv | 174 +++++++++++++++++
 tb/tb_vga_pxl_unpack.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pxl_unpack_if.sv
// Bus bundle between the pixel FIFO read port, the unpacker and the colour/timing stage.
//   fifo_empty : FIFO has no data (FIFO -> unpacker)
//   fifo_rreq  : pop request; fifo_q valid the following cycle (unpacker -> FIFO)
//   fifo_q     : FIFO read data (FIFO -> unpacker)
//   pix_valid  : pix_data holds a pixel (unpacker -> consumer)
//   pix_ready  : consumer accepts the pixel this cycle (consumer -> unpacker)
//   pix_data   : pixel {R,G,B} (unpacker -> consumer)
// master = unpacker side, slave = FIFO/consumer side.
interface vga_pxl_unpack_if #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned PWIDTH = 24
);
   logic              fifo_empty;
   logic              fifo_rreq;
   logic [DWIDTH-1:0] fifo_q;
   logic              pix_valid;
   logic              pix_ready;
   logic [PWIDTH-1:0] pix_data;

   modport master (
      input  fifo_empty, fifo_q, pix_ready,
      output fifo_rreq, pix_valid, pix_data
   );

   modport slave (
      output fifo_empty, fifo_q, pix_ready,
      input  fifo_rreq, pix_valid, pix_data
   );
endinterface

// File: rtl/vga_pxl_unpack.sv
// Unpacks 32-bit FIFO words into 24-bit RGB pixels (8bpp grey, RGB565, 24bpp packed, 32bpp).
// Ports:
//   clk   : system clock, rising edge
//   aclr  : asynchronous active-low reset
//   sclr  : synchronous clear (frame restart); drops held words, phase and pending read
//   bpp   : 00 grey, 01 RGB565, 10 24bpp packed, 11 32bpp; latched only while idle
//   bswap : (VGA_BSWAP_EN only) byte-reverse each captured word; latched with bpp
//   busy  : any word held, read pending or pixel valid
//   bus   : FIFO read port and pixel valid/ready handshake (master modport)
// Optional feature macro: VGA_BSWAP_EN.
module vga_pxl_unpack #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned PWIDTH = 24
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             sclr,
   input  logic [1:0]       bpp,
`ifdef VGA_BSWAP_EN
   input  logic             bswap,
`endif
   output logic             busy,
   vga_pxl_unpack_if.master bus
);

   typedef enum logic [1:0] {
      MODE_GREY  = 2'b00,
      MODE_565   = 2'b01,
      MODE_RGB24 = 2'b10,
      MODE_RGB32 = 2'b11
   } mode_e;

   logic [DWIDTH-1:0] w0, w1;
   logic [1:0]        cnt;
   logic              pend;
   logic [1:0]        phase;
   mode_e             mode_q;
   logic              valid_q;
   logic [PWIDTH-1:0] data_q;
`ifdef VGA_BSWAP_EN
   logic              swap_q;
`endif

   logic [DWIDTH-1:0] word_in, w0_n, w1_n;
   logic [1:0]        cnt_n, phase_n;
   logic [15:0]       half;
   logic [7:0]        grey;
   logic [PWIDTH-1:0] pix;
   logic              have, retire, load, rreq, valid_n, busy_n;

   // Pop while a slot is free that no in-flight read has already claimed.
   assign rreq = aclr & ~sclr & ~bus.fifo_empty & ((2'd2 - cnt) > {1'b0, pend});

   assign bus.fifo_rreq = rreq;
   assign bus.pix_valid = valid_q;
   assign bus.pix_data  = data_q;

   // Pixel selection, slot bookkeeping and next state.
   always_comb begin
      word_in = bus.fifo_q;
`ifdef VGA_BSWAP_EN
      if (swap_q)
         word_in = {bus.fifo_q[7:0], bus.fifo_q[15:8], bus.fifo_q[23:16], bus.fifo_q[31:24]};
`endif
      half = phase[0] ? w0[31:16] : w0[15:0];
      case (phase)
         2'd0:    grey = w0[7:0];
         2'd1:    grey = w0[15:8];
         2'd2:    grey = w0[23:16];
         default: grey = w0[31:24];
      endcase

      have    = (cnt != 2'd0);
      retire  = 1'b0;
      pix     = '0;
      phase_n = phase + 2'd1;
      case (mode_q)
         MODE_RGB32: begin
            pix     = w0[23:0];
            retire  = 1'b1;
            phase_n = 2'd0;
         end
         MODE_565: begin
            pix     = {half[15:11], half[15:13], half[10:5], half[10:9], half[4:0], half[4:2]};
            retire  = phase[0];
            phase_n = {1'b0, ~phase[0]};
         end
         MODE_GREY: begin
            pix    = {grey, grey, grey};
            retire = (phase == 2'd3);
         end
         default: begin
            // 24bpp: phases 1 and 2 straddle two words, so both slots must be full.
            case (phase)
               2'd0: pix = w0[23:0];
               2'd1: pix = {w1[15:0], w0[31:24]};
               2'd2: pix = {w1[7:0], w0[31:16]};
               default: pix = w0[31:8];
            endcase
            retire = (phase != 2'd0);
            if (phase == 2'd1 || phase == 2'd2)
               have = (cnt == 2'd2);
         end
      endcase

      load = (~valid_q | bus.pix_ready) & have;

      // Retire shifts W1 down first; the returning read then lands in the first free slot.
      w0_n  = w0;
      w1_n  = w1;
      cnt_n = cnt;
      if (load && retire) begin
         w0_n  = w1;
         cnt_n = cnt - 2'd1;
      end
      if (pend) begin
         if (cnt_n == 2'd0)
            w0_n = word_in;
         else
            w1_n = word_in;
         cnt_n = cnt_n + 2'd1;
      end

      valid_n = valid_q;
      if (~valid_q | bus.pix_ready)
         valid_n = have;

      busy_n = (cnt_n != 2'd0) | rreq | valid_n;
   end

   // State registers; sclr overrides everything except the idle mode latch.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         w0      <= '0;
         w1      <= '0;
         cnt     <= 2'd0;
         pend    <= 1'b0;
         phase   <= 2'd0;
         mode_q  <= MODE_GREY;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy    <= 1'b0;
`ifdef VGA_BSWAP_EN
         swap_q  <= 1'b0;
`endif
      end else begin
         if (!busy) begin
            mode_q <= mode_e'(bpp);
`ifdef VGA_BSWAP_EN
            swap_q <= bswap;
`endif
         end
         if (sclr) begin
            cnt     <= 2'd0;
            pend    <= 1'b0;
            phase   <= 2'd0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
         end else begin
            w0      <= w0_n;
            w1      <= w1_n;
            cnt     <= cnt_n;
            pend    <= rreq;
            valid_q <= valid_n;
            busy    <= busy_n;
            if (load) begin
               data_q <= pix;
               phase  <= phase_n;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_pxl_unpack.sv
// Directed bench for vga_pxl_unpack: FIFO model with registered read data, pixel monitor.
module tb_vga_pxl_unpack;
   logic       clk  = 1'b0;
   logic       aclr = 1'b0;
   logic       sclr = 1'b0;
   logic [1:0] bpp  = 2'b11;
`ifdef VGA_BSWAP_EN
   logic       bswap = 1'b0;
`endif
   logic       busy;

   vga_pxl_unpack_if ifc ();

   vga_pxl_unpack dut (
      .clk   (clk),
      .aclr  (aclr),
      .sclr  (sclr),
      .bpp   (bpp),
`ifdef VGA_BSWAP_EN
      .bswap (bswap),
`endif
      .busy  (busy),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // FIFO model: pushes from the test tasks, pops on rreq with one-cycle read latency.
   logic [31:0] mem [0:63];
   int          pushed    = 0;
   int          popped    = 0;
   int          underflow = 0;
   logic [31:0] fq        = 32'h0;

   assign ifc.fifo_empty = (pushed == popped);
   assign ifc.fifo_q     = fq;

   always @(posedge clk) begin
      if (ifc.fifo_rreq) begin
         if (pushed == popped) underflow <= underflow + 1;
         fq     <= mem[popped[5:0]];
         popped <= popped + 1;
      end
   end

   // Pixel monitor: records every accepted pixel and the cycle it was accepted in.
   int          cyc = 0;
   logic [23:0] got     [0:255];
   int          got_cyc [0:255];
   int          nout = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (aclr && ifc.pix_valid === 1'b1 && ifc.pix_ready === 1'b1) begin
         got[nout[7:0]]     = ifc.pix_data;
         got_cyc[nout[7:0]] = cyc;
         nout               = nout + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      mem[pushed[5:0]] = w;
      pushed           = pushed + 1;
   endtask

   task automatic wait_pix(input int target, output bit ok);
      int n;
      n = 0;
      while (nout < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      ok = (nout >= target);
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      aclr          = 1'b0;
      ifc.pix_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (ifc.fifo_rreq !== 1'b0) begin errors++; $display("FAIL reset_rreq: got %b want 0", ifc.fifo_rreq); end
      checks++; if (ifc.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.pix_valid); end
      checks++; if (ifc.pix_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", ifc.pix_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      step();
      aclr = 1'b1;
      step();
   endtask

   task automatic test_32bpp();
      int base;
      bit ok;
      bpp = 2'b11;
      ifc.pix_ready = 1'b1;
      step(); step();
      base = nout;
      push(32'h11AABBCC);
      push(32'h22DDEEFF);
      wait_pix(base + 2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb32_timeout: got %0d pixels want %0d", nout - base, 2); end
      checks++; if (got[base] !== 24'hAABBCC) begin errors++; $display("FAIL rgb32_p0: got %h want aabbcc", got[base]); end
      checks++; if (got[base+1] !== 24'hDDEEFF) begin errors++; $display("FAIL rgb32_p1: got %h want ddeeff", got[base+1]); end
      checks++; if (got_cyc[base+1] - got_cyc[base] !== 1) begin errors++; $display("FAIL rgb32_b2b: got gap %0d want 1", got_cyc[base+1] - got_cyc[base]); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb32_idle: busy %b want 0", busy); end
   endtask

   task automatic test_24bpp();
      logic [23:0] exp [8];
      int base;
      bit ok;
      exp = '{24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA,
              24'h020100, 24'h050403, 24'h080706, 24'h0B0A09};
      bpp = 2'b10;
      step(); step();
      base = nout;
      push(32'h44332211); push(32'h88776655); push(32'hCCBBAA99);
      push(32'h03020100); push(32'h07060504); push(32'h0B0A0908);
      wait_pix(base + 8, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb24_timeout: got %0d pixels want 8", nout - base); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[base+i] !== exp[i]) begin errors++; $display("FAIL rgb24_p%0d: got %h want %h", i, got[base+i], exp[i]); end
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb24_idle: busy %b want 0", busy); end
   endtask

   task automatic test_16_8bpp();
      logic [23:0] exp16 [4];
      logic [23:0] exp8  [4];
      int base;
      bit ok;
      exp16 = '{24'hFF0000, 24'h0000FF, 24'h848284, 24'h00FF00};
      exp8  = '{24'h010101, 24'h000000, 24'hFFFFFF, 24'h808080};
      bpp = 2'b01;
      step(); step();
      base = nout;
      push(32'h001FF800);
      push(32'h07E08410);
      wait_pix(base + 4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rgb565_timeout: got %0d pixels want 4", nout - base); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[base+i] !== exp16[i]) begin errors++; $display("FAIL rgb565_p%0d: got %h want %h", i, got[base+i], exp16[i]); end
      end
      wait_idle(ok);
      bpp = 2'b00;
      step(); step();
      base = nout;
      push(32'h80FF0001);
      wait_pix(base + 4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL grey_timeout: got %0d pixels want 4", nout - base); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[base+i] !== exp8[i]) begin errors++; $display("FAIL grey_p%0d: got %h want %h", i, got[base+i], exp8[i]); end
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL grey_idle: busy %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int base;
      int pbase;
      bit ok;
      bpp = 2'b11;
      ifc.pix_ready = 1'b0;
      step(); step();
      base  = nout;
      pbase = popped;
      for (int k = 1; k <= 6; k++) push(32'h5A000000 | (32'(k) * 32'h00010101));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 5) begin
            checks++;
            if (ifc.pix_valid !== 1'b1 || ifc.pix_data !== 24'h010101) begin
               errors++; $display("FAIL stall_hold_%0d: got valid %b data %h want 1 010101", i, ifc.pix_valid, ifc.pix_data);
            end
         end
      end
      checks++; if (popped - pbase > 3) begin errors++; $display("FAIL stall_pops: got %0d want <= 3", popped - pbase); end
      step();
      ifc.pix_ready = 1'b1;
      wait_pix(base + 6, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d pixels want 6", nout - base); end
      for (int k = 1; k <= 6; k++) begin
         checks++;
         if (got[base+k-1] !== 24'(k * 32'h00010101)) begin
            errors++; $display("FAIL stall_p%0d: got %h want %h", k - 1, got[base+k-1], 24'(k * 32'h00010101));
         end
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_idle: busy %b want 0", busy); end
   endtask

   task automatic test_sclr();
      int base;
      bit ok;
      bpp = 2'b10;
      ifc.pix_ready = 1'b1;
      step(); step();
      base = nout;
      push(32'h44332211);
      push(32'h88776655);
      wait_pix(base + 2, ok);
      repeat (3) step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sclr_pre_busy: got %b want 1", busy); end
      push(32'hCCBBAA99);
      step();
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      @(negedge clk);
      checks++; if (ifc.pix_valid !== 1'b0) begin errors++; $display("FAIL sclr_valid: got %b want 0", ifc.pix_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sclr_busy: got %b want 0", busy); end
      checks++; if (nout !== base + 2) begin errors++; $display("FAIL sclr_count: got %0d pixels want 2", nout - base); end
      step();
      push(32'h5A123456);
      wait_pix(base + 3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sclr_timeout: got %0d pixels want 3", nout - base); end
      checks++; if (got[base+2] !== 24'h123456) begin errors++; $display("FAIL sclr_p0: got %h want 123456", got[base+2]); end
      step();
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sclr_idle: busy %b want 0", busy); end
   endtask

`ifdef VGA_BSWAP_EN
   task automatic test_bswap();
      int base;
      bit ok;
      bpp   = 2'b11;
      bswap = 1'b1;
      step(); step();
      base = nout;
      push(32'h11223344);
      wait_pix(base + 1, ok);
      checks++; if (got[base] !== 24'h332211) begin errors++; $display("FAIL bswap_p0: got %h want 332211", got[base]); end
      wait_idle(ok);
      bswap = 1'b0;
      step(); step();
   endtask
`endif

   task automatic test_aclr_mid();
      int base;
      bit ok;
      bpp = 2'b11;
      ifc.pix_ready = 1'b0;
      step(); step();
      push(32'h5A0A0B0C); push(32'h5A0D0E0F); push(32'h5A101112);
      repeat (6) step();
      push(32'h5A131415);
      @(negedge clk);
      checks++; if (ifc.pix_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL aclr_pre: got valid %b busy %b want 1 1", ifc.pix_valid, busy); end
      step();
      aclr = 1'b0;
      #1;
      checks++; if (ifc.pix_valid !== 1'b0) begin errors++; $display("FAIL aclr_valid: got %b want 0", ifc.pix_valid); end
      checks++; if (ifc.pix_data !== 24'h0) begin errors++; $display("FAIL aclr_data: got %h want 000000", ifc.pix_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aclr_busy: got %b want 0", busy); end
      checks++; if (ifc.fifo_rreq !== 1'b0) begin errors++; $display("FAIL aclr_rreq: got %b want 0", ifc.fifo_rreq); end
      step(); step();
      aclr = 1'b1;
      base = nout;
      step();
      ifc.pix_ready = 1'b1;
      wait_pix(base + 1, ok);
      checks++; if (got[base] !== 24'h131415) begin errors++; $display("FAIL aclr_resume: got %h want 131415", got[base]); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL aclr_idle: busy %b want 0", busy); end
   endtask

   initial begin
      ifc.pix_ready = 1'b0;
      test_reset();
      test_32bpp();
      test_24bpp();
      test_16_8bpp();
      test_back_to_back();
      test_sclr();
`ifdef VGA_BSWAP_EN
      test_bswap();
`endif
      test_aclr_mid();
      checks++; if (underflow !== 0) begin errors++; $display("FAIL fifo_underflow: got %0d pops of empty FIFO want 0", underflow); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
